// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game round timer.
package game_timer_pkg;

  // Controller states; running covers RUN and PAUSED, expired is EXPIRED only.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Largest value the two seconds digits can show.
  localparam int unsigned MAX_SECS = 99;

  // Two-digit BCD seconds value.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Binary seconds to two BCD digits, clamped to MAX_SECS.
  function automatic bcd2_t to_bcd2(input int unsigned secs);
    int unsigned v;
    bcd2_t       r;
    v      = (secs > MAX_SECS) ? MAX_SECS : secs;
    r.tens = BCD_W'(v / 10);
    r.ones = BCD_W'(v % 10);
    return r;
  endfunction

endpackage : game_timer_pkg

// File: rtl/game_timer_bcd2_add_sat.sv
// Combinational two-digit BCD adder that saturates at 99.
module bcd2_add_sat
  import game_timer_pkg::*;
(
  input  bcd2_t a_i,
  input  bcd2_t b_i,
  output bcd2_t sum_o
);

  localparam int SUM_W = BCD_W + 1;

  logic [SUM_W-1:0] ones_raw;
  logic [SUM_W-1:0] tens_raw;
  logic             carry;

  // Add the ones digits, fold any decimal carry into the tens, clamp above 99.
  // NOTE: every signal written in this block is given a value on every path
  // (defaults first), so no latch can be inferred.
  always_comb begin
    ones_raw = {1'b0, a_i.ones} + {1'b0, b_i.ones};
    carry    = (ones_raw > SUM_W'(9));
    tens_raw = {1'b0, a_i.tens} + {1'b0, b_i.tens} + {{BCD_W{1'b0}}, carry};

    sum_o.ones = carry ? BCD_W'(ones_raw - SUM_W'(10)) : ones_raw[BCD_W-1:0];
    sum_o.tens = tens_raw[BCD_W-1:0];

    // A tens digit past 9 means the total exceeded 99.
    if (tens_raw > SUM_W'(9)) begin
      sum_o = to_bcd2(MAX_SECS);
    end
  end

endmodule : bcd2_add_sat

// File: rtl/game_timer.sv
// Countdown round timer: 1 Hz prescaler, BCD seconds, pause, bonus, timeout.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned START_SECS = 30,
  parameter int unsigned BONUS_SECS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             bonus,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic             expired,
  output logic             timeout
);

  // A 1 Hz clock would give $clog2 of 0; keep at least one prescaler bit.
  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  localparam bcd2_t START_BCD = to_bcd2(START_SECS);
  localparam bcd2_t BONUS_BCD = to_bcd2(BONUS_SECS);
  localparam bcd2_t ZERO_BCD  = '0;

  state_e               state_q,   state_d;
  logic [PRESC_W-1:0]   presc_q,   presc_d;
  bcd2_t                digits_q,  digits_d;
  logic                 timeout_q, timeout_d;

  logic  counting;   // RUN or PAUSED: the round is live
  logic  advance;    // live and not held by pause: prescaler moves this cycle
  logic  tick;       // last cycle of the current second
  bcd2_t bonus_sum;  // digits plus bonus, saturated
  bcd2_t sum;        // digits after an optional bonus, before any decrement
  bcd2_t dec;        // sum minus one second

  bcd2_add_sat u_bonus_add (
    .a_i   (digits_q),
    .b_i   (BONUS_BCD),
    .sum_o (bonus_sum)
  );

  // Pause acts as a level: the prescaler stands still whenever it is high,
  // and moves again on the very cycle it drops, so the partial second survives.
  assign counting = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign advance  = counting && !pause;
  assign tick     = advance && (presc_q == PRESC_MAX);

  // Bonus is applied before the decrement, so bonus+tick gives value+bonus-1
  // and bonus+tick at 00 gives bonus-1 with no timeout.
  always_comb begin
    sum = (counting && bonus) ? bonus_sum : digits_q;
    dec = sum;
    if (sum.ones == '0) begin
      dec.ones = BCD_W'(9);
      dec.tens = sum.tens - BCD_W'(1);
    end else begin
      dec.ones = sum.ones - BCD_W'(1);
    end
  end

  // Next state, prescaler, digits and timeout pulse; start overrides everything.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    digits_d  = digits_q;
    timeout_d = 1'b0;

    if (start) begin
      state_d  = ST_RUN;
      presc_d  = '0;
      digits_d = START_BCD;
    end else begin
      case (state_q)
        ST_RUN, ST_PAUSED: begin
          state_d  = pause ? ST_PAUSED : ST_RUN;
          digits_d = sum;
          if (advance) begin
            if (tick) begin
              presc_d = '0;
              if (sum == ZERO_BCD) begin
                state_d   = ST_EXPIRED;
                timeout_d = 1'b1;
              end else begin
                digits_d = dec;
              end
            end else begin
              presc_d = presc_q + PRESC_ONE;
            end
          end
        end
        ST_EXPIRED: begin
          presc_d  = '0;
          digits_d = ZERO_BCD;
        end
        default: begin
          // IDLE: digits and prescaler hold until start.
        end
      endcase
    end
  end

  // State register.
  // NOTE: sequential logic uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: prescaler, BCD digits and the registered timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      digits_q  <= START_BCD;
      timeout_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      digits_q  <= digits_d;
      timeout_q <= timeout_d;
    end
  end

  assign sec_tens = digits_q.tens;
  assign sec_ones = digits_q.ones;
  assign running  = counting;
  assign expired  = (state_q == ST_EXPIRED);
  assign timeout  = timeout_q;

endmodule : game_timer
